// File: rtl/ddr3_phy_pkg.sv
// Shared types and constants for the DDR3 PHY command/address delay control.
// Holds the tap controller state set and delay-line encoding constants.
package ddr3_phy_pkg;

  localparam int   DLY_TAP_W   = 8;
  localparam logic DLY_DIR_INC = 1'b1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    SETDIR,
    MOVE,
    SETTLE,
    FIN,
    FAIL
  } ca_dly_state_t;

endpackage

// File: rtl/ddr3_ca_dly_ctrl.sv
// Per-lane CA delay-line tap controller: walks an IOD delay line to an
// absolute tap one step at a time, with a settle gap after every pulse.
module ddr3_ca_dly_ctrl
  import ddr3_phy_pkg::*;
#(
  parameter int TAP_W      = DLY_TAP_W,
  parameter int MAX_TAP    = 255,
  parameter int LOAD_TAP   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_LOAD,
  input  logic [TAP_W-1:0] REQ_TAP,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  localparam int CNT_W =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [TAP_W-1:0] MAX_T  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] LOAD_T = TAP_W'(LOAD_TAP);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(SETTLE_CYC - 1);

  ca_dly_state_t    state_q, state_d;
  logic [TAP_W-1:0] cur_q, cur_d;
  logic [TAP_W-1:0] prev_q, prev_d;
  logic [TAP_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             op_load_q, op_load_d;
  logic             init_q, init_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             move_q, move_d;
  logic             oor_q;

  logic [TAP_W-1:0] req_clamp;
  logic             accept;
  logic             step_inc;

  assign req_clamp = (REQ_TAP > MAX_T) ? MAX_T : REQ_TAP;
  assign accept    = REQ_VALID & ready_q;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    prev_d    = prev_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    err_d     = err_q;
    op_load_d = op_load_q;
    init_d    = init_q;
    step_inc  = 1'b0;

    unique case (state_q)
      INIT: begin
        init_d  = 1'b1;
        state_d = LOAD;
      end
      IDLE: begin
        if (accept) begin
          tgt_d  = req_clamp;
          err_d  = 1'b0;
          init_d = 1'b0;
          if (REQ_LOAD)
            state_d = LOAD;
          else if (req_clamp == cur_q)
            state_d = FIN;
          else
            state_d = SETDIR;
        end
      end
      LOAD: begin
        cnt_d   = CNT_INIT;
        state_d = SETTLE;
      end
      SETDIR: begin
        state_d = MOVE;
      end
      MOVE: begin
        cnt_d   = CNT_INIT;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!op_load_q && oor_q) begin
          cur_d   = prev_q;
          state_d = FAIL;
        end else if (op_load_q || cur_q == tgt_q) begin
          state_d = FIN;
        end else begin
          state_d = SETDIR;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      FAIL: begin
        state_d = IDLE;
      end
    endcase

    // Entry actions keyed on the next state so outputs can be registered.
    if (state_d == LOAD) begin
      cur_d     = LOAD_T;
      op_load_d = 1'b1;
    end

    if (state_d == SETDIR) begin
      op_load_d = 1'b0;
      step_inc  = (tgt_d > cur_d);
      dir_d     = step_inc ? DLY_DIR_INC : ~DLY_DIR_INC;
      // A step off either end of the line is never issued.
      if ((step_inc && cur_d == MAX_T) ||
          (!step_inc && cur_d == '0))
        state_d = FAIL;
    end

    if (state_d == MOVE) begin
      prev_d = cur_q;
      cur_d  = (dir_q == DLY_DIR_INC) ?
               cur_q + TAP_W'(1) : cur_q - TAP_W'(1);
    end

    if (state_d == FAIL)
      err_d = 1'b1;

    ready_d = (state_d == IDLE);
    load_d  = (state_d == LOAD);
    move_d  = (state_d == MOVE);
    done_d  = (state_d == FAIL) ||
              (state_d == FIN && !init_d);
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      cur_q     <= LOAD_T;
      prev_q    <= LOAD_T;
      tgt_q     <= LOAD_T;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      op_load_q <= 1'b0;
      init_q    <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      move_q    <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      prev_q    <= prev_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
      op_load_q <= op_load_d;
      init_q    <= init_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      load_q    <= load_d;
      move_q    <= move_d;
      oor_q     <= DELAY_LINE_OUT_OF_RANGE;
    end
  end

  assign REQ_READY            = ready_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;
  assign CUR_TAP              = cur_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_ddr3_ca_dly_ctrl.sv
// Randomized bench for ddr3_ca_dly_ctrl with a cycle-trace reference
// model derived from the tap-walk timing rules.
module tb_ddr3_ca_dly_ctrl;

  localparam int TW   = 9;
  localparam int MAXT = 255;
  localparam int LT   = 1;
  localparam int S    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          valid = 1'b0;
  logic          rld = 1'b0;
  logic          oor = 1'b0;
  logic [TW-1:0] rtap = '0;
  logic          ready, done, err, dl_load, dl_move, dl_dir;
  logic [TW-1:0] cur;

  ddr3_ca_dly_ctrl #(
    .TAP_W(TW), .MAX_TAP(MAXT), .LOAD_TAP(LT), .SETTLE_CYC(S)
  ) dut (
    .FAB_CLK(clk),
    .ARST_N(rst_n),
    .REQ_VALID(valid),
    .REQ_READY(ready),
    .REQ_LOAD(rld),
    .REQ_TAP(rtap),
    .DONE(done),
    .ERR(err),
    .CUR_TAP(cur),
    .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move),
    .DELAY_LINE_DIRECTION(dl_dir),
    .DELAY_LINE_OUT_OF_RANGE(oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ld, mv, dr, dn, rd, er;
    int cur;
  } exp_t;

  exp_t exp_q[$];
  bit   oor_arr[4096];
  int   glen;
  int   m_cur = LT;
  bit   m_err, m_dir;
  int   nchk, nerr;

  task automatic chk(input string nm, input int act, input int want);
    nchk++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, want, $time);
    end
  endtask

  task automatic push(input bit ld, mv, dr, dn, rd, er,
                      input int c, input bit o);
    exp_t e;
    e.ld = ld; e.mv = mv; e.dr = dr; e.dn = dn;
    e.rd = rd; e.er = er; e.cur = c;
    exp_q.push_back(e);
    oor_arr[glen] = o;
    glen++;
  endtask

  // Expected trace from the accept cycle through the DONE cycle.
  task automatic gen(input bit ld, input int req, input int inj);
    int c, t, n, nxt;
    bit inc;
    c = m_cur;
    push(0, 0, m_dir, 0, 1, m_err, c, 0);
    m_err = 0;
    if (ld) begin
      push(1, 0, m_dir, 0, 0, 0, LT, 0);
      for (int i = 0; i < S; i++) push(0, 0, m_dir, 0, 0, 0, LT, 0);
      push(0, 0, m_dir, 1, 0, 0, LT, 0);
      m_cur = LT;
      return;
    end
    t = (req > MAXT) ? MAXT : req;
    if (t == c) begin
      push(0, 0, m_dir, 1, 0, 0, c, 0);
      return;
    end
    inc = (t > c);
    n = inc ? t - c : c - t;
    m_dir = inc;
    for (int k = 0; k < n; k++) begin
      nxt = inc ? c + 1 : c - 1;
      push(0, 0, inc, 0, 0, 0, c, 0);
      push(0, 1, inc, 0, 0, 0, nxt, (k + 1 == inj));
      for (int i = 0; i < S; i++)
        push(0, 0, inc, 0, 0, 0, nxt, (k + 1 == inj));
      if (k + 1 == inj) begin
        push(0, 0, inc, 1, 0, 1, c, 0);
        m_err = 1;
        m_cur = c;
        return;
      end
      c = nxt;
    end
    push(0, 0, inc, 1, 0, 0, c, 0);
    m_cur = c;
  endtask

  task automatic run_op(input bit ld, input int req, input int inj,
                        input int abort, output int len);
    glen = 0;
    gen(ld, req, inj);
    len   = glen;
    valid = 1'b1;
    rld   = ld;
    rtap  = TW'(req);
    oor   = oor_arr[0];
    for (int i = 1; i <= len; i++) begin
      @(posedge clk) #2;
      if (abort != 0 && i == abort) return;
      valid = 1'b0;
      oor   = (i < len) ? oor_arr[i] : 1'b0;
    end
  endtask

  task automatic idle_cycle();
    glen = 0;
    push(0, 0, m_dir, 0, 1, m_err, m_cur, 0);
    @(posedge clk) #2;
  endtask

  task automatic do_reset();
    int len;
    rst_n = 1'b0;
    valid = 1'b0;
    oor   = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_load", dl_load, 0);
    chk("rst_move", dl_move, 0);
    chk("rst_dir", dl_dir, 0);
    chk("rst_cur", cur, LT);
    @(posedge clk) #2;
    @(posedge clk) #2;
    rst_n = 1'b1;
    m_cur = LT; m_err = 0; m_dir = 0;
    glen = 0;
    push(0, 0, 0, 0, 0, 0, LT, 0);
    push(1, 0, 0, 0, 0, 0, LT, 0);
    for (int i = 0; i < S; i++) push(0, 0, 0, 0, 0, 0, LT, 0);
    push(0, 0, 0, 0, 0, 0, LT, 0);
    len = glen;
    chk("init_len", len, S + 3);
    for (int i = 1; i <= len; i++) @(posedge clk) #2;
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("load", dl_load, e.ld);
      chk("move", dl_move, e.mv);
      chk("dir", dl_dir, e.dr);
      chk("done", done, e.dn);
      chk("ready", ready, e.rd);
      chk("err", err, e.er);
      chk("cur_tap", cur, e.cur);
    end
  end

  initial begin
    #700000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    @(posedge clk) #2;
    do_reset();
    idle_cycle();

    run_op(0, 4, 0, 0, len);
    chk("lat_up3", len, 20);
    chk("cur_up3", cur, 4);
    run_op(0, 2, 0, 0, len);
    chk("lat_dn2", len, 14);
    chk("cur_dn2", cur, 2);
    run_op(0, 2, 0, 0, len);
    chk("lat_same", len, 2);

    run_op(1, 0, 0, 0, len);
    run_op(0, 300, 3, 0, len);
    chk("lat_oor", len, 20);
    chk("err_oor", err, 1);
    chk("cur_oor", cur, 3);
    run_op(0, 3, 0, 0, len);
    chk("err_clr", err, 0);

    run_op(0, 300, 0, 0, len);
    chk("lat_clamp", len, 1 + 252 * (2 + S) + 1);
    chk("cur_clamp", cur, 255);
    run_op(0, 511, 0, 0, len);
    chk("lat_top", len, 2);
    chk("cur_top", cur, 255);

    run_op(0, 7, 0, 0, len);
    chk("cur_7", cur, 7);
    run_op(1, 0, 0, 0, len);
    chk("lat_load", len, 7);
    chk("cur_load", cur, 1);

    run_op(0, 10, 0, 4, len);
    do_reset();
    chk("cur_rst", cur, 1);

    for (int k = 0; k < 80; k++) begin
      int req, inj, t, n, idl;
      bit ld;
      ld  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0)
        req = $urandom_range(0, 511);
      else
        req = m_cur + $urandom_range(0, 12) - 6;
      if (req < 0) req = 0;
      if (req > 511) req = 511;
      t = (req > MAXT) ? MAXT : req;
      n = (t > m_cur) ? t - m_cur : m_cur - t;
      inj = 0;
      if (!ld && n > 0 && $urandom_range(0, 7) == 0)
        inj = $urandom_range(1, n);
      run_op(ld, req, inj, 0, len);
      idl = $urandom_range(0, 2);
      for (int i = 0; i < idl; i++) idle_cycle();
    end

    idle_cycle();
    @(posedge clk) #2;
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ddr3_ca_dly_ctrl.md
Name: ddr3_ca_dly_ctrl

Overview:
Per-lane delay-line tap controller for the DDR3 PHY command/address IODs (WE_N, RAS_N, CAS_N, address lanes). It sits directly upstream of an IOD wrapper and drives that wrapper's DELAY_LINE_LOAD / MOVE / DIRECTION inputs. It consumes the wrapper's DELAY_LINE_OUT_OF_RANGE output. Training logic requests an absolute tap value; the block steps the line one tap at a time with settle gaps and tracks the current tap.

Parameters:
TAP_W, 8, width of tap counters and request.
MAX_TAP, 255, highest legal tap; requests above this are clamped.
LOAD_TAP, 1, tap value the line holds after DELAY_LINE_LOAD; matches the IOD TX_DELAY_VAL.
SETTLE_CYC, 4, FAB_CLK cycles to wait after each LOAD/MOVE pulse (>=1).

Ports:
FAB_CLK  in  1  fabric clock, same as the IOD TX_CLK.
ARST_N  in  1  asynchronous active-low reset.
REQ_VALID  in  1  request valid.
REQ_READY  out  1  block can accept a request.
REQ_LOAD  in  1  with REQ_VALID: reload the line to LOAD_TAP; REQ_TAP is ignored.
REQ_TAP  in  TAP_W  target tap.
DONE  out  1  one-cycle pulse; request completed.
ERR  out  1  sticky out-of-range flag.
CUR_TAP  out  TAP_W  tracked current tap.
DELAY_LINE_LOAD  out  1  to IOD, one-cycle pulse.
DELAY_LINE_MOVE  out  1  to IOD, one-cycle pulse.
DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment, 0 = decrement.
DELAY_LINE_OUT_OF_RANGE  in  1  from IOD.

Behaviour:
- One clock (FAB_CLK); reset is asynchronous, active-low (ARST_N). All outputs are registered.
- Reset values: REQ_READY=0, DONE=0, ERR=0, LOAD=0, MOVE=0, DIRECTION=0, CUR_TAP=LOAD_TAP.
- States: INIT, IDLE, LOAD, SETDIR, MOVE, SETTLE, FIN, FAIL.
- INIT: first cycle after reset release. Behaves as LOAD, and FIN does not pulse DONE for it. This makes the line state known after any reset, including a reset in the middle of an operation.
- IDLE:
  - REQ_READY=1.
  - A request is accepted on REQ_VALID & REQ_READY. On acceptance, latch target = min(REQ_TAP, MAX_TAP) and clear ERR.
  - REQ_LOAD=1 -> LOAD.
  - target==CUR_TAP -> FIN.
  - Otherwise -> SETDIR.
- LOAD: DELAY_LINE_LOAD=1 for this cycle; CUR_TAP<=LOAD_TAP; -> SETTLE.
- SETDIR: DELAY_LINE_DIRECTION<=(target>CUR_TAP); -> MOVE. DIRECTION is therefore stable one cycle before the MOVE pulse and held through SETTLE.
- MOVE: DELAY_LINE_MOVE=1 for this cycle; CUR_TAP steps +/-1 toward the target; -> SETTLE.
- SETTLE:
  - Counts SETTLE_CYC cycles, then evaluates the OOR input registered once in this block.
  - If OOR=1 after a MOVE: CUR_TAP reverts to its pre-step value, ERR<=1, -> FAIL.
  - Else if CUR_TAP==target or the op was a LOAD -> FIN.
  - Else -> SETDIR.
- FIN: DONE=1 for one cycle (suppressed for INIT); -> IDLE.
- FAIL: DONE=1 for one cycle; -> IDLE. ERR stays 1 until the next accepted request.
- CUR_TAP is saturating: it never wraps below 0 or above MAX_TAP. A step that would leave that range is not issued; the block goes to FAIL with ERR=1.
- Latency (S=SETTLE_CYC, accept cycle = 0):
  - target==CUR_TAP: DONE at cycle 1.
  - LOAD: DONE at cycle 2+S.
  - N-tap move: DONE at cycle 1+N*(2+S).
  - REQ_READY returns 1 the cycle after DONE.
- LOAD and MOVE are never asserted in the same cycle. Neither is asserted outside the LOAD, INIT and MOVE states.
- Requests presented while REQ_READY=0 are not accepted; the requester must hold REQ_VALID.

Decomposition:
- Shared package ddr3_phy_pkg holds:
  - the state enum ca_dly_state_t (INIT, IDLE, LOAD, SETDIR, MOVE, SETTLE, FIN, FAIL);
  - the constant DLY_TAP_W=8;
  - the constant DLY_DIR_INC=1'b1.
- No sub-module. The settle counter and step logic stay inline; a separate module would only wrap a counter.

Test Plan:
- Reset release, S=4: LOAD pulse at cycle 0, REQ_READY=1 at cycle 6, no DONE pulse, CUR_TAP=1.
- From tap 1, REQ_TAP=4: 3 MOVE pulses with DIRECTION=1 set one cycle before each pulse, MOVE pulses 6 cycles apart, DONE at cycle 19, CUR_TAP=4.
- From tap 4, REQ_TAP=2: 2 decrement MOVE pulses, DONE at cycle 13, CUR_TAP=2. Then REQ_TAP=2: DONE at cycle 1 with no MOVE.
- REQ_TAP=300 with MAX_TAP=255: target is clamped to 255. Force OOR=1 on step 3 from tap 1: CUR_TAP=3, ERR=1, DONE pulses. The next request clears ERR.
- Assert ARST_N low during SETTLE of a multi-step move: all outputs return to reset values immediately. After release, the INIT load sequence runs and CUR_TAP=1.
- REQ_LOAD=1 while CUR_TAP=7: one LOAD pulse, no MOVE, DONE at cycle 6, CUR_TAP=1.
